// File: rtl/calc_seq_if.sv
// Command/result handshake bundle between a client and calc_seq.
// The master side issues commands and accepts results; the slave side is the sequencer.
interface calc_seq_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [2:0]       out_err;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_err
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_err
  );
endinterface

// File: rtl/calc_seq.sv
// Command sequencer in front of int_calc: holds operands for a settle window, screens
// bad commands, and builds power out of repeated calculator multiplies.
module calc_seq #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned MAX_EXP = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  calc_seq_if.slave        bus,
  output logic [2:0]       calc_op,
  output logic [WIDTH-1:0] calc_opa,
  output logic [WIDTH-1:0] calc_opb,
  input  logic [WIDTH-1:0] calc_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, POW, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t           state;
  logic [3:0]       settle_cnt;
  logic [6:0]       exp_cnt;
  logic [WIDTH-1:0] out_result;
  logic [2:0]       out_err;

  logic b_zero, div_zero, illegal, exp_range, is_pow;

  always_comb begin
    b_zero    = (bus.in_b == '0);
    div_zero  = ((bus.in_op == 3'b011) || (bus.in_op == 3'b100)) && b_zero;
    illegal   = (bus.in_op == 3'b110) || (bus.in_op == 3'b111);
    is_pow    = (bus.in_op == 3'b101);
    exp_range = is_pow && (bus.in_b > WIDTH'(MAX_EXP));
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.out_result = out_result;
  assign bus.out_err    = out_err;

  // calc_opa doubles as the power accumulator: each step multiplies it by the base in calc_opb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      exp_cnt    <= '0;
      out_result <= '0;
      out_err    <= '0;
      calc_op    <= '0;
      calc_opa   <= '0;
      calc_opb   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            out_err    <= '0;
            settle_cnt <= '0;
            if (div_zero) begin
              out_result <= '0;
              out_err    <= 3'b001;
              state      <= DONE;
            end else if (illegal) begin
              out_result <= '0;
              out_err    <= 3'b010;
              state      <= DONE;
            end else if (exp_range) begin
              out_result <= '0;
              out_err    <= 3'b100;
              state      <= DONE;
            end else if (is_pow && b_zero) begin
              out_result <= WIDTH'(1);
              state      <= DONE;
            end else if (is_pow) begin
              exp_cnt  <= 7'(bus.in_b);
              calc_op  <= 3'b010;
              calc_opa <= WIDTH'(1);
              calc_opb <= bus.in_a;
              state    <= POW;
            end else begin
              calc_op  <= bus.in_op;
              calc_opa <= bus.in_a;
              calc_opb <= bus.in_b;
              state    <= ISSUE;
            end
          end
        end

        ISSUE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            out_result <= calc_out;
            state      <= DONE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end

        POW: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            exp_cnt    <= exp_cnt - 7'd1;
            if (exp_cnt == 7'd1) begin
              out_result <= calc_out;
              state      <= DONE;
            end else begin
              calc_opa <= calc_out;
            end
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end

        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_seq.sv
// Bench for calc_seq: behavioural calculator model, vector table with a result scoreboard,
// and hand-written sequences for power stepping, backpressure and mid-power reset.
module tb_calc_seq;
  localparam int unsigned WIDTH   = 64;
  localparam int unsigned SETTLE  = 2;
  localparam int unsigned MAX_EXP = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       calc_op;
  logic [WIDTH-1:0] calc_opa, calc_opb, calc_out;

  always #5 clk = ~clk;

  calc_seq_if #(.WIDTH(WIDTH)) bus ();

  calc_seq #(.WIDTH(WIDTH), .SETTLE(SETTLE), .MAX_EXP(MAX_EXP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .calc_op  (calc_op),
    .calc_opa (calc_opa),
    .calc_opb (calc_opb),
    .calc_out (calc_out)
  );

  // Calculator model; the power opcode is deliberately unmodelled since it must never be issued.
  always_comb begin
    calc_out = '0;
    case (calc_op)
      3'b000: calc_out = calc_opa + calc_opb;
      3'b001: calc_out = calc_opa - calc_opb;
      3'b010: calc_out = calc_opa * calc_opb;
      3'b011: calc_out = (calc_opb == '0) ? '0 : calc_opa / calc_opb;
      3'b100: calc_out = (calc_opb == '0) ? '0 : calc_opa % calc_opb;
      default: calc_out = '0;
    endcase
  end

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic [2:0]  err;
    int          lat;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic [2:0]  err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] res, input logic [2:0] err, input int lat);
    exp_t e;
    e.res = res;
    e.err = err;
    e.lat = lat;
    sb.push_back(e);
  endtask

  // Leaves in_valid high across the acceptance edge; returns at the negedge right after it.
  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 64'(bus.in_ready), 64'd1);
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Counts clock edges after the acceptance edge until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk("out_valid_timeout", 64'(bus.out_valid), 64'd1);
  endtask

  task automatic consume(input int lat);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk("out_result", bus.out_result, e.res);
      chk("out_err", 64'(bus.out_err), 64'(e.err));
      chk("latency", 64'(lat), 64'(e.lat));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[16];
    int          lat;
    logic [2:0]  p_op;
    logic [63:0] p_a, p_b;

    vt[0]  = '{3'b000, 64'd5, 64'd7, 64'd12, 3'b000, 2};
    vt[1]  = '{3'b001, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 3'b000, 2};
    vt[2]  = '{3'b010, 64'h1_0000_0000, 64'h1_0000_0001, 64'h1_0000_0000, 3'b000, 2};
    vt[3]  = '{3'b011, 64'd100, 64'd7, 64'd14, 3'b000, 2};
    vt[4]  = '{3'b100, 64'd100, 64'd7, 64'd2, 3'b000, 2};
    vt[5]  = '{3'b011, 64'd9, 64'd0, 64'd0, 3'b001, 0};
    vt[6]  = '{3'b100, 64'd9, 64'd0, 64'd0, 3'b001, 0};
    vt[7]  = '{3'b110, 64'd4, 64'd0, 64'd0, 3'b010, 0};
    vt[8]  = '{3'b111, 64'd4, 64'd4, 64'd0, 3'b010, 0};
    vt[9]  = '{3'b101, 64'd3, 64'd4, 64'd81, 3'b000, 8};
    vt[10] = '{3'b101, 64'd0, 64'd0, 64'd1, 3'b000, 0};
    vt[11] = '{3'b101, 64'd2, 64'd64, 64'd0, 3'b000, 128};
    vt[12] = '{3'b101, 64'd2, 64'd65, 64'd0, 3'b100, 0};
    vt[13] = '{3'b101, 64'd5, 64'h1_0000_0000_0002, 64'd0, 3'b100, 0};
    vt[14] = '{3'b101, 64'd0, 64'd5, 64'd0, 3'b000, 10};
    vt[15] = '{3'b101, 64'd5, 64'd1, 64'd5, 3'b000, 2};

    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_result", bus.out_result, 64'd0);
    chk("rst_out_err", 64'(bus.out_err), 64'd0);
    chk("rst_calc_op", 64'(calc_op), 64'd0);
    chk("rst_calc_opa", calc_opa, 64'd0);
    chk("rst_calc_opb", calc_opb, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      p_op = calc_op;
      p_a  = calc_opa;
      p_b  = calc_opb;
      push_exp(vt[i].res, vt[i].err, vt[i].lat);
      issue(vt[i].op, vt[i].a, vt[i].b);
      if (vt[i].lat == 0) begin
        chk("calc_op_held", 64'(calc_op), 64'(p_op));
        chk("calc_opa_held", calc_opa, p_a);
        chk("calc_opb_held", calc_opb, p_b);
      end else if (vt[i].op == 3'b101) begin
        chk("pow_calc_op", 64'(calc_op), 64'd2);
        chk("pow_calc_opa", calc_opa, 64'd1);
        chk("pow_calc_opb", calc_opb, vt[i].a);
      end else begin
        chk("calc_op", 64'(calc_op), 64'(vt[i].op));
        chk("calc_opa", calc_opa, vt[i].a);
        chk("calc_opb", calc_opb, vt[i].b);
      end
      wait_out(lat);
      consume(lat);
    end

    // Power stepping: the multiplicand advances 1, 3, 9, 27 once per settle window.
    push_exp(64'd81, 3'b000, 2);
    issue(3'b101, 64'd3, 64'd4);
    chk("pow_seq_opa0", calc_opa, 64'd1);
    for (int s = 1; s < 4; s++) begin
      repeat (SETTLE) @(negedge clk);
      chk("pow_seq_op", 64'(calc_op), 64'd2);
      chk("pow_seq_opa", calc_opa, (s == 1) ? 64'd3 : (s == 2) ? 64'd9 : 64'd27);
      chk("pow_seq_busy", 64'(bus.in_ready), 64'd0);
    end
    wait_out(lat);
    consume(lat);

    // Backpressure: result held five cycles while a waiting command is refused.
    push_exp(64'd42, 3'b000, 2);
    issue(3'b000, 64'd20, 64'd22);
    wait_out(lat);
    bus.in_op    = 3'b010;
    bus.in_a     = 64'd6;
    bus.in_b     = 64'd9;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_result", bus.out_result, 64'd42);
      chk("bp_err", 64'(bus.out_err), 64'd0);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
    end
    consume(lat);
    chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
    push_exp(64'd54, 3'b000, 2);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_next_op", 64'(calc_op), 64'd2);
    wait_out(lat);
    consume(lat);

    // Reset in the second power step aborts the command without a result.
    issue(3'b101, 64'd3, 64'd4);
    repeat (SETTLE) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_result", bus.out_result, 64'd0);
    chk("mid_rst_err", 64'(bus.out_err), 64'd0);
    chk("mid_rst_calc_op", 64'(calc_op), 64'd0);
    chk("mid_rst_calc_opa", calc_opa, 64'd0);
    chk("mid_rst_calc_opb", calc_opb, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.out_valid) lat++;
    end
    chk("mid_rst_no_valid", 64'(lat), 64'd0);
    push_exp(64'd12, 3'b000, 2);
    issue(3'b000, 64'd5, 64'd7);
    wait_out(lat);
    consume(lat);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
